minibyte_cpu_core: RTL and testbench

- Parametrised successor to the minibyte CPU top level: same A/M/PC register model, plus a real instruction fetch/decode/execute FSM replacing the hard-tied control signals.
- Generalised in data width and address width.
- Adds a memory ready handshake, Z/N flags with conditional branches, and a halt state.
- Sits between the chip-level IO wrapper and external memory/IO.

---
 rtl/minibyte_pkg.sv | 45 ++++
 rtl/minibyte_alu_p.sv | 52 +++++
 rtl/minibyte_cpu_core.sv | 149 ++++++++++++++
 tb/tb_minibyte_cpu_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minibyte_pkg.sv
// Shared opcodes, FSM state and ALU-op encodings for the minibyte CPU.
// MINIBYTE_CPU_CARRY_EN adds the C flag and turns opcode C into JC.
package minibyte_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JN  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {ST_FETCH, ST_OPERAND, ST_EXEC, ST_HALT} state_e;

  typedef enum logic [2:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_e;

  function automatic alu_op_e alu_op_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

  // Opcodes that are followed by an operand word.
  function automatic logic has_operand(input logic [3:0] op);
    logic r;
    r = (op >= OP_LDI) && (op <= OP_JN);
`ifdef MINIBYTE_CPU_CARRY_EN
    r = r || (op == OP_JC);
`endif
    return r;
  endfunction

endpackage

// File: rtl/minibyte_alu_p.sv
// Combinational ALU: pass-through, add, subtract and bitwise ops with Z/N
// flags; C output present only under MINIBYTE_CPU_CARRY_EN.
module minibyte_alu_p
  import minibyte_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n
`ifdef MINIBYTE_CPU_CARRY_EN
  ,
  output logic              c
`endif
);

`ifdef MINIBYTE_CPU_CARRY_EN
  localparam int EXT_W = DATA_W + 1;
`else
  localparam int EXT_W = DATA_W;
`endif

  logic [EXT_W-1:0] add_w;
  logic [EXT_W-1:0] sub_w;

  assign add_w = EXT_W'(a) + EXT_W'(b);
  assign sub_w = EXT_W'(a) - EXT_W'(b);

  always_comb begin
    result = b;
    case (op)
      ALU_ADD: result = add_w[DATA_W-1:0];
      ALU_SUB: result = sub_w[DATA_W-1:0];
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = b;
    endcase
  end

  assign z = (result == '0);
  assign n = result[DATA_W-1];

`ifdef MINIBYTE_CPU_CARRY_EN
  // For SUB the top bit of the widened difference is the borrow.
  assign c = (op == ALU_SUB) ? ~sub_w[DATA_W] : add_w[DATA_W];
`endif

endmodule

// File: rtl/minibyte_cpu_core.sv
// minibyte CPU: A/M/PC register model with fetch/operand/exec/halt FSM and
// a memory ready handshake. MINIBYTE_CPU_CARRY_EN enables the C flag and JC.
module minibyte_cpu_core
  import minibyte_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rdy_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              we_out,
  output logic              halt_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [3:0]        ir_q, ir_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
`ifdef MINIBYTE_CPU_CARRY_EN
  logic              c_q, c_d;
  logic              alu_c;
`endif

  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_n;
  logic [ADDR_W-1:0] opnd_addr;
  logic [3:0]        fetch_op;

  assign opnd_addr = data_in[ADDR_W-1:0];
  assign fetch_op  = data_in[3:0];
  assign data_out  = a_q;

  minibyte_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (data_in),
    .op     (alu_op_of(ir_q)),
    .result (alu_res),
    .z      (alu_z),
    .n      (alu_n)
`ifdef MINIBYTE_CPU_CARRY_EN
    ,
    .c      (alu_c)
`endif
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      m_q     <= '0;
      a_q     <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef MINIBYTE_CPU_CARRY_EN
      c_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      m_q     <= m_d;
      a_q     <= a_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      n_q     <= n_d;
`ifdef MINIBYTE_CPU_CARRY_EN
      c_q     <= c_d;
`endif
    end
  end

  // With rdy_in low every register keeps its value, so all outputs hold.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    m_d      = m_q;
    a_d      = a_q;
    ir_d     = ir_q;
    z_d      = z_q;
    n_d      = n_q;
`ifdef MINIBYTE_CPU_CARRY_EN
    c_d      = c_q;
`endif
    addr_out = pc_q;
    we_out   = 1'b0;
    halt_out = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (rdy_in) begin
          ir_d = fetch_op;
          pc_d = pc_q + ADDR_W'(1);
          if (fetch_op == OP_HLT)        state_d = ST_HALT;
          else if (has_operand(fetch_op)) state_d = ST_OPERAND;
          else                            state_d = ST_FETCH;
        end
      end
      ST_OPERAND: begin
        if (rdy_in) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
          case (ir_q)
            OP_LDI: begin
              a_d = alu_res;
              z_d = alu_z;
              n_d = alu_n;
            end
            OP_JMP: pc_d = opnd_addr;
            OP_JZ:  if (z_q) pc_d = opnd_addr;
            OP_JN:  if (n_q) pc_d = opnd_addr;
`ifdef MINIBYTE_CPU_CARRY_EN
            OP_JC:  if (c_q) pc_d = opnd_addr;
`endif
            default: begin
              m_d     = opnd_addr;
              state_d = ST_EXEC;
            end
          endcase
        end
      end
      ST_EXEC: begin
        addr_out = m_q;
        we_out   = (ir_q == OP_STA);
        if (rdy_in) begin
          state_d = ST_FETCH;
          if (ir_q != OP_STA) begin
            a_d = alu_res;
            z_d = alu_z;
            n_d = alu_n;
          end
`ifdef MINIBYTE_CPU_CARRY_EN
          if ((ir_q == OP_ADD) || (ir_q == OP_SUB)) c_d = alu_c;
`endif
        end
      end
      ST_HALT: begin
        halt_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_minibyte_cpu_core.sv
// Self-checking bench for minibyte_cpu_core: an instruction-level reference
// model predicts every bus cycle under directed and randomized programs.
module tb_minibyte_cpu_core;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       rdy_in = 1'b0;
  logic [7:0] data_in, addr_out, data_out;
  logic       we_out, halt_out;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  assign data_in = mem[addr_out];

  minibyte_cpu_core #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .rdy_in   (rdy_in),
    .addr_out (addr_out),
    .data_out (data_out),
    .we_out   (we_out),
    .halt_out (halt_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural model state plus the bus accesses of the current instruction.
  logic [7:0] m_pc, m_a;
  bit         m_z, m_n, m_c, m_halt;
  int         e_n, phase;
  logic [7:0] e_addr [3];
  bit         e_we   [3];
  logic [7:0] n_pc, n_a, n_wa;
  bit         n_z, n_n, n_c, n_halt, n_wr;
  int         wr_cnt, exp_wr, first_we, first_halt;

  task automatic model_reset();
    m_pc = 8'h00; m_a = 8'h00;
    m_z = 0; m_n = 0; m_c = 0; m_halt = 0;
    phase = 0; wr_cnt = 0; exp_wr = 0;
  endtask

  task automatic build();
    logic [7:0] w, p1, opd, b;
    logic [3:0] op;
    int  r;
    bit  has_r, take;
    w = ref_mem[m_pc]; op = w[3:0];
    p1 = m_pc + 8'd1; opd = ref_mem[p1]; b = ref_mem[opd];
    e_addr[0] = m_pc; e_addr[1] = p1; e_addr[2] = opd;
    e_we[0] = 0; e_we[1] = 0; e_we[2] = 0;
    n_pc = p1; n_a = m_a; n_z = m_z; n_n = m_n; n_c = m_c;
    n_halt = 0; n_wr = 0; n_wa = opd;
    e_n = 1; take = 0; has_r = 0; r = 0;
    case (op)
      4'h1: begin e_n = 2; r = int'(opd); has_r = 1; end
      4'h2: begin e_n = 3; r = int'(b); has_r = 1; end
      4'h3: begin e_n = 3; e_we[2] = 1; n_wr = 1; end
      4'h4: begin e_n = 3; r = int'(m_a) + int'(b); n_c = (r > 255); has_r = 1; end
      4'h5: begin e_n = 3; r = int'(m_a) - int'(b); n_c = (m_a >= b); has_r = 1; end
      4'h6: begin e_n = 3; r = int'(m_a & b); has_r = 1; end
      4'h7: begin e_n = 3; r = int'(m_a | b); has_r = 1; end
      4'h8: begin e_n = 3; r = int'(m_a ^ b); has_r = 1; end
      4'h9: begin e_n = 2; take = 1; end
      4'hA: begin e_n = 2; take = m_z; end
      4'hB: begin e_n = 2; take = m_n; end
      4'hC: begin
`ifdef MINIBYTE_CPU_CARRY_EN
        e_n = 2; take = m_c;
`endif
      end
      4'hF: n_halt = 1;
      default: ;
    endcase
    if (e_n == 3) n_pc = p1 + 8'd1;
    if (e_n == 2) n_pc = take ? opd : p1 + 8'd1;
    if (has_r) begin
      r = r & 255;
      n_a = r[7:0]; n_z = (r == 0); n_n = r[7];
    end
  endtask

  task automatic commit();
    if (n_wr) begin ref_mem[n_wa] = m_a; exp_wr++; end
    m_pc = n_pc; m_a = n_a; m_z = n_z; m_n = n_n; m_c = n_c; m_halt = n_halt;
  endtask

  // mode 0: rdy always high; 1: random rdy; 2: 4 stall cycles at first write.
  task automatic run(input string name, input int max_cyc, input int mode);
    int post = 0, stall = 0, diff = 0;
    bit stalled = 0, rdy;
    logic [7:0] ex_addr;
    bit ex_we;
    first_we = -1; first_halt = -1;
    for (int cyc = 0; cyc < max_cyc && post < 4; cyc++) begin
      if (!m_halt && phase == 0) build();
      ex_addr = m_halt ? m_pc : e_addr[phase];
      ex_we   = m_halt ? 1'b0 : e_we[phase];
      if (mode == 0) rdy = 1;
      else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else begin
        if (!stalled && ex_we) begin stalled = 1; stall = 4; end
        rdy = (stall == 0);
        if (stall > 0) stall--;
      end
      rdy_in = rdy;
      #1;
      chk({name, "_addr"}, 32'(addr_out), 32'(ex_addr));
      chk({name, "_we"},   32'(we_out),   32'(ex_we));
      chk({name, "_data"}, 32'(data_out), 32'(m_a));
      chk({name, "_halt"}, 32'(halt_out), 32'(m_halt));
      if (we_out && first_we < 0) first_we = cyc;
      if (halt_out && first_halt < 0) first_halt = cyc;
      if (rdy && we_out) begin mem[addr_out] = data_out; wr_cnt++; end
      if (m_halt) post++;
      if (rdy && !m_halt) begin
        phase++;
        if (phase == e_n) begin commit(); phase = 0; end
      end
      @(negedge clk_in);
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk({name, "_mem"},    32'(diff),   32'(0));
    chk({name, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  task automatic reset_begin();
    @(negedge clk_in);
    rst_in = 1'b0;
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
      #1;
      chk("rst_addr", 32'(addr_out), 32'(0));
      chk("rst_data", 32'(data_out), 32'(0));
      chk("rst_we",   32'(we_out),   32'(0));
      chk("rst_halt", 32'(halt_out), 32'(0));
      @(negedge clk_in);
    end
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
  endtask

  task automatic reset_end();
    for (int j = 0; j < 256; j++) ref_mem[j] = mem[j];
    model_reset();
    rst_in = 1'b1;
  endtask

  task automatic load_prog1();
    mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h04; mem[3] = 8'h10;
    mem[4] = 8'h03; mem[5] = 8'h11; mem[6] = 8'h0F;
    mem[8'h10] = 8'hFB; mem[8'h11] = 8'hAA;
  endtask

  initial begin
    // LDI/ADD/STA then halt
    reset_begin(); load_prog1(); reset_end();
    run("prog1", 40, 0);
    chk("prog1_first_we",   32'(first_we),   32'(7));
    chk("prog1_first_halt", 32'(first_halt), 32'(9));
    chk("prog1_A",          32'(data_out),   32'(8'h00));
    chk("prog1_mem11",      32'(mem[8'h11]), 32'(8'h00));
    chk("prog1_halt_addr",  32'(addr_out),   32'(8'h07));

    // Branching on N then Z
    reset_begin();
    mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'h0B; mem[3] = 8'h20;
    mem[8'h20] = 8'h01; mem[8'h21] = 8'h00; mem[8'h22] = 8'h0A; mem[8'h23] = 8'h30;
    mem[8'h30] = 8'h0F;
    reset_end();
    run("branch", 40, 0);
    chk("branch_halt",      32'(halt_out),   32'(1));
    chk("branch_halt_addr", 32'(addr_out),   32'(8'h31));
    chk("branch_cycles",    32'(first_halt), 32'(9));

    // Stall during STA exec
    reset_begin(); load_prog1(); reset_end();
    run("stall", 60, 2);
    chk("stall_one_write",  32'(wr_cnt),     32'(1));
    chk("stall_mem11",      32'(mem[8'h11]), 32'(8'h00));
    chk("stall_first_halt", 32'(first_halt), 32'(13));

    // PC wrap with operand fetched from address 0
    reset_begin();
    mem[0] = 8'h7E; mem[1] = 8'h09; mem[2] = 8'hFF; mem[8'hFF] = 8'h01;
    reset_end();
    run("wrap", 5, 0);
    chk("wrap_A",  32'(data_out), 32'(8'h7E));
    chk("wrap_pc", 32'(addr_out), 32'(8'h01));

    // Carry then JC (NOP without the carry feature)
    reset_begin();
    mem[0] = 8'h01; mem[1] = 8'hFF; mem[2] = 8'h04; mem[3] = 8'h50;
    mem[4] = 8'h0C; mem[5] = 8'h40; mem[6] = 8'h0F; mem[7] = 8'h00;
    mem[8'h40] = 8'h0F; mem[8'h50] = 8'h01;
    reset_end();
    run("carry", 40, 0);
    chk("carry_A", 32'(data_out), 32'(8'h00));
`ifdef MINIBYTE_CPU_CARRY_EN
    chk("carry_halt_addr", 32'(addr_out), 32'(8'h41));
`else
    chk("carry_halt_addr", 32'(addr_out), 32'(8'h07));
`endif

    // Asynchronous reset in the middle of a stalled STA exec
    reset_begin();
    mem[0] = 8'h01; mem[1] = 8'h55; mem[2] = 8'h03; mem[3] = 8'h40; mem[4] = 8'h0F;
    reset_end();
    for (int i = 0; i < 4; i++) begin rdy_in = 1'b1; @(negedge clk_in); end
    rdy_in = 1'b0;
    #1;
    chk("rstmid_we_before",   32'(we_out),   32'(1));
    chk("rstmid_addr_before", 32'(addr_out), 32'(8'h40));
    #2 rst_in = 1'b0;
    #1;
    chk("rstmid_we",   32'(we_out),   32'(0));
    chk("rstmid_addr", 32'(addr_out), 32'(0));
    chk("rstmid_data", 32'(data_out), 32'(0));
    rdy_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rstmid_we_edge", 32'(we_out), 32'(0));
    @(negedge clk_in);
    reset_end();
    run("after_rst", 30, 0);
    chk("after_rst_mem40", 32'(mem[8'h40]), 32'(8'h55));

    // Random programs with random ready
    for (int t = 0; t < 6; t++) begin
      reset_begin();
      for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
      reset_end();
      run("rand", 400, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
